prio_arb_rr: RTL and testbench
==============================

# prio_arb_rr

Parametrised, registered request arbiter: the sequential successor to the team's combinational 8-bit priority encoder. It takes N request lines, selects one in fixed-priority (highest index wins) or round-robin mode, and holds a registered one-hot grant plus its binary index until the requester acknowledges or withdraws. It sits behind the `ui_in`/`uio_in` pin decode of a `tt_um_*` top and drives `uo_out`.

## Interface
Parameters:
- `N`, 8: number of request lines; legal range 2..32.
- `IDX_W`, `$clog2(N)`: width of `grant_idx`. Derived; never overridden.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  when 0, all state registers hold and no arbitration occurs.
- `req`  in  N  request lines; level-sensitive.
- `mode`  in  1  0 = fixed priority, 1 = round-robin.
- `ack`  in  1  releases the current grant; ignored while `valid`=0.
- `mask_in`  in  N  mask load value; used only with `PRIO_ARB_MASK_EN`.
- `mask_we`  in  1  mask load strobe; used only with `PRIO_ARB_MASK_EN`.
- `grant`  out  N  registered one-hot grant; all zero when `valid`=0.
- `grant_idx`  out  IDX_W  binary index of the granted line; 0 when `valid`=0.
- `valid`  out  1  a grant is held.
- `gnt_new`  out  1  one-cycle strobe on the first cycle of every new grant.

## Operation
- Effective request: `ereq = req & mask`. Without the macro, `mask` is all ones.
- Two states:
  - `IDLE` (`valid`=0).
  - `GRANT` (`valid`=1).
- Arbitration happens on an edge with `ena`=1, when in `IDLE` or when releasing in `GRANT`:
  - Fixed mode: the highest set index of `ereq` wins.
  - Round-robin mode: scan downward from `ptr`, wrapping from 0 to N-1; the first set bit of `ereq` wins.
- `ptr` is an IDX_W-bit register:
  - Reset value N-1.
  - On every grant to line g, `ptr` ← (g-1) mod N, so g becomes lowest priority.
  - Updated in both modes, so a switch to round-robin continues fairly.
- IDLE → GRANT: any `ereq` bit is set. The winner is registered into `grant`/`grant_idx`, `valid`=1 and `gnt_new`=1.
- A release in `GRANT` happens when `ack`=1, or when `req[grant_idx]`=0 (withdrawal), or both. Both together count as one release. On the release edge:
  - If `ereq` (the released line included) has any bit set, arbitrate immediately. The new winner is registered, `valid` stays 1 and `gnt_new`=1. The same line may be re-granted.
  - Otherwise go to `IDLE`: `grant`=0, `grant_idx`=0, `valid`=0.
- While holding with no release: `grant` is stable and `gnt_new`=0. Requests from other lines and changes to `mode` have no effect until the next arbitration.
- Index arithmetic is unsigned modulo N, for any N, not only powers of two.

## Timing
- All outputs are registered. Reset values: `grant`=0, `grant_idx`=0, `valid`=0, `gnt_new`=0. Internal: `ptr`=N-1, `mask`=all ones.
- Latency: a request seen at edge k gives `grant` valid after edge k (one cycle from the request being sampled).
- Back-to-back grants need no idle cycle: with `ack` high at edge k, the next grant is visible after edge k.
- `ena`=0: registers hold, except `gnt_new`, which goes to 0. `ack`, request withdrawal and `mask_we` are not sampled.
- Asserting `rst_n` low mid-grant clears every register immediately, without waiting for a clock edge.

## Configuration
- `PRIO_ARB_MASK_EN` defined:
  - Adds an N-bit `mask` register, reset to all ones.
  - `mask_we`=1 with `ena`=1 loads `mask_in` at the edge.
  - A newly loaded mask first affects arbitration on the following edge.
  - Masking the currently granted line does not revoke its grant.
- Macro undefined:
  - `mask` is the constant all ones.
  - `mask_in` and `mask_we` are ignored.
  - The port list is the same in both builds.

## Test plan
All scenarios use N=8.
- Reset, then `req`=8'b1001_0100 with `mode`=0 → after one edge: `grant`=8'b1000_0000, `grant_idx`=7, `valid`=1, `gnt_new`=1 for one cycle.
- Fixed mode, `req`=8'hFF held, `ack` pulsed on four consecutive edges → the grant stays on line 7 each time and `gnt_new` pulses each time.
- Round-robin mode, `req`=8'hFF held, `ack` high continuously → `grant_idx` sequence 7, 6, 5, …, 0, 7, with `valid` never dropping.
- Round-robin mode, `req`=8'b0010_0001, line 5 granted, then `req[5]` dropped with `ack`=0 → next edge: `grant_idx`=0 and `gnt_new`=1. Then `req`=0 with `ack`=1 → `valid`=0 and `grant`=0.
- `ena`=0 during a held grant with `ack`=1 → grant unchanged and `gnt_new`=0. Then `rst_n` pulsed low between clock edges → all outputs 0 immediately, and the next arbitration uses `ptr`=7.
- With `PRIO_ARB_MASK_EN`: load mask 8'b0111_1111, then `req`=8'hFF → `grant_idx`=6. Without the macro, the same stimulus → `grant_idx`=7.

Source files
------------

// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered N-way arbiter with fixed-priority or round-robin selection
// Optional request masking is enabled by defining PRIO_ARB_MASK_EN.
module prio_arb_rr #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             ack,
    input  logic [N-1:0]     mask_in,
    input  logic             mask_we,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid,
    output logic             gnt_new
);
    logic [N-1:0]     mask, ereq;
    logic [IDX_W-1:0] ptr, hi_all, hi_lo, win;
    logic             lo_hit, any, rel;

`ifdef PRIO_ARB_MASK_EN
    // mask register; a new value only influences arbitration from the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask <= '1;
        else if (ena && mask_we)
            mask <= mask_in;
    end
`else
    logic unused_mask;
    assign mask        = '1;
    assign unused_mask = ^{mask_in, mask_we};
`endif

    assign ereq = req & mask;
    assign any  = |ereq;
    assign rel  = !valid || ack || !req[grant_idx];
    assign win  = mode ? (lo_hit ? hi_lo : hi_all) : hi_all;

    // highest request overall and highest request at or below ptr; the latter
    // is the first hit of a downward scan from ptr, the former covers the wrap
    always_comb begin
        hi_all = '0;
        hi_lo  = '0;
        lo_hit = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (ereq[c]) begin
                hi_all = IDX_W'(c);
                if (c <= int'(ptr)) begin
                    hi_lo  = IDX_W'(c);
                    lo_hit = 1'b1;
                end
            end
        end
    end

    // grant state: arbitrate from idle or on release, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            grant_idx <= '0;
            valid     <= 1'b0;
            gnt_new   <= 1'b0;
            ptr       <= IDX_W'(N - 1);
        end else if (ena && rel && any) begin
            grant     <= N'(1) << win;
            grant_idx <= win;
            valid     <= 1'b1;
            gnt_new   <= 1'b1;
            ptr       <= (win == '0) ? IDX_W'(N - 1) : win - 1'b1;
        end else if (ena && rel) begin
            grant     <= '0;
            grant_idx <= '0;
            valid     <= 1'b0;
            gnt_new   <= 1'b0;
        end else begin
            gnt_new   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prio_arb_rr.sv
// tb_prio_arb_rr: directed and random checks of prio_arb_rr against a reference model
module tb_prio_arb_rr;
    localparam int N = 8;

    logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b0, mode = 1'b0, ack = 1'b0, mask_we = 1'b0;
    logic [N-1:0] req = '0, mask_in = '0;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         valid, gnt_new;

    int tests = 0;
    int fails = 0;

    int           m_ptr, m_idx;
    bit           m_valid, m_new;
    logic [N-1:0] m_mask;

    prio_arb_rr #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .mode(mode), .ack(ack),
        .mask_in(mask_in), .mask_we(mask_we), .grant(grant), .grant_idx(grant_idx),
        .valid(valid), .gnt_new(gnt_new)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] e, input logic md);
        for (int k = 0; k < N; k++) begin
            int c = md ? (m_ptr - k + N) % N : N - 1 - k;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = N - 1;
        m_idx   = 0;
        m_valid = 0;
        m_new   = 0;
        m_mask  = '1;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic md, input logic ak,
                              input logic en, input logic [N-1:0] mi, input logic mw);
        int w;
        m_new = 0;
        if (!en) return;
        if (!m_valid || ak || !r[m_idx]) begin
            w = pick(r & m_mask, md);
            if (w >= 0) begin
                m_valid = 1;
                m_idx   = w;
                m_new   = 1;
                m_ptr   = (w + N - 1) % N;
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end
`ifdef PRIO_ARB_MASK_EN
        if (mw) m_mask = mi;
`else
        if (mw) m_mask = m_mask | mi;
`endif
    endtask

    task automatic compare_all();
        check("grant", 32'(grant), m_valid ? 32'(1) << m_idx : 32'd0);
        check("grant_idx", 32'(grant_idx), 32'(m_idx));
        check("valid", 32'(valid), 32'(m_valid));
        check("gnt_new", 32'(gnt_new), 32'(m_new));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic md, input logic ak,
                       input logic en, input logic [N-1:0] mi, input logic mw);
        req = r; mode = md; ack = ak; ena = en; mask_in = mi; mask_we = mw;
        @(posedge clk);
        model_edge(r, md, ak, en, mi, mw);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        compare_all();
        rst_n = 1'b1;

        cyc(8'b1001_0100, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("first_grant", 32'(grant), 32'h80);
        check("first_idx", 32'(grant_idx), 32'd7);
        check("first_new", 32'(gnt_new), 32'd1);
        cyc(8'b1001_0100, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("hold_new", 32'(gnt_new), 32'd0);

        for (int k = 0; k < 4; k++) begin
            cyc(8'hFF, 1'b0, 1'b1, 1'b1, '0, 1'b0);
            check("fixed_idx", 32'(grant_idx), 32'd7);
            check("fixed_new", 32'(gnt_new), 32'd1);
        end

        do_reset();
        for (int k = 0; k < 9; k++) begin
            cyc(8'hFF, 1'b1, 1'b1, 1'b1, '0, 1'b0);
            check("rr_idx", 32'(grant_idx), 32'((7 - k + 8) % 8));
            check("rr_valid", 32'(valid), 32'd1);
        end

        do_reset();
        cyc(8'b0010_0001, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        check("rr5_idx", 32'(grant_idx), 32'd5);
        cyc(8'b0000_0001, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        check("withdraw_idx", 32'(grant_idx), 32'd0);
        check("withdraw_new", 32'(gnt_new), 32'd1);
        cyc(8'h00, 1'b1, 1'b1, 1'b1, '0, 1'b0);
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_grant", 32'(grant), 32'd0);

        cyc(8'hFF, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("ena0_grant", 32'(grant), 32'h80);
        check("ena0_new", 32'(gnt_new), 32'd0);
        do_reset();
        check("async_valid", 32'(valid), 32'd0);
        cyc(8'hFF, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        check("post_reset_ptr", 32'(grant_idx), 32'd7);

        do_reset();
        cyc(8'h00, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1);
        cyc(8'hFF, 1'b0, 1'b0, 1'b1, '0, 1'b0);
`ifdef PRIO_ARB_MASK_EN
        check("mask_idx", 32'(grant_idx), 32'd6);
`else
        check("mask_idx", 32'(grant_idx), 32'd7);
`endif

        do_reset();
        for (int k = 0; k < 500; k++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            else if ($urandom_range(0, 3) == 0) r = N'(1) << $urandom_range(0, N - 1);
            if ($urandom_range(0, 99) == 0) do_reset();
            cyc(r, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 9) != 0, N'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
